// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite line scheduler and its per-sprite pixel hit logic.
package sprite_pkg;

    localparam int SPR_W   = 40;
    localparam int SPR_H   = 24;
    localparam int COORD_W = 11;

    typedef enum logic {IDLE, SCAN} sched_state_t;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/sprite_pixel_hit.sv
// Combinational pixel test for one sprite: is the current pixel inside the sprite and opaque in its fetched row.
module sprite_pixel_hit
    import sprite_pkg::*;
#(
    parameter int W = sprite_pkg::SPR_W
) (
    input  logic [W-1:0] row,
    input  logic         act,
    input  coord_t       spr_x,
    input  coord_t       pix_x,
    input  logic         video_on,
    output logic         hit
);

    localparam int CW = COORD_W + 1;

    logic [CW-1:0] px_w;
    logic [CW-1:0] sx_w;
    logic [CW-1:0] dx_w;
    logic          in_range;
    logic [W-1:0]  shifted;

    // 12-bit compare keeps spr_x + W from wrapping near the right edge of the coordinate space
    always_comb begin
        px_w     = {1'b0, pix_x};
        sx_w     = {1'b0, spr_x};
        dx_w     = px_w - sx_w;
        in_range = (px_w >= sx_w) && (px_w < sx_w + CW'(W));
        shifted  = row << dx_w;
        hit      = act & video_on & in_range & shifted[W-1];
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Time-shares one sprite ROM across NSPR sprites: fetches rows during hblank, paints from row registers during active video.
module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int NSPR  = 4,
    parameter int SPR_W = sprite_pkg::SPR_W,
    parameter int SPR_H = sprite_pkg::SPR_H,
    parameter int AW    = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    line_start,
    input  logic [COORD_W-1:0]      line_y,
    input  logic [COORD_W-1:0]      pix_x,
    input  logic                    video_on,
    input  logic [NSPR-1:0]         spr_en,
    input  logic [NSPR*COORD_W-1:0] spr_x,
    input  logic [NSPR*COORD_W-1:0] spr_y,
    output logic [AW-1:0]           rom_addr,
    input  logic [SPR_W-1:0]        rom_data,
    output logic                    paint,
    output logic [2:0]              paint_id,
    output logic                    busy
);

    localparam int IW = (NSPR > 1) ? $clog2(NSPR) : 1;
    localparam int CW = COORD_W + 1;

    sched_state_t     state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    coord_t           ly_q, ly_d;
    logic [SPR_W-1:0] row_q [NSPR];
    logic [SPR_W-1:0] row_d [NSPR];
    logic [NSPR-1:0]  act_q, act_d;
    logic             paint_q, paint_d;
    logic [2:0]       paint_id_q, paint_id_d;

    coord_t           spr_x_arr [NSPR];
    coord_t           spr_y_arr [NSPR];
    logic [NSPR-1:0]  hit;

    logic [CW-1:0]    ly_w;
    logic [CW-1:0]    y_w;
    logic             scan_hit;

    generate
        for (genvar gi = 0; gi < NSPR; gi++) begin : g_spr
            assign spr_x_arr[gi] = spr_x[gi*COORD_W +: COORD_W];
            assign spr_y_arr[gi] = spr_y[gi*COORD_W +: COORD_W];

            sprite_pixel_hit #(
                .W (SPR_W)
            ) u_hit (
                .row      (row_q[gi]),
                .act      (act_q[gi]),
                .spr_x    (spr_x_arr[gi]),
                .pix_x    (pix_x),
                .video_on (video_on),
                .hit      (hit[gi])
            );
        end
    endgenerate

    // Vertical test for the sprite under scan, widened so spr_y + SPR_H cannot wrap
    always_comb begin
        ly_w     = {1'b0, ly_q};
        y_w      = {1'b0, spr_y_arr[idx_q]};
        scan_hit = spr_en[idx_q] && (ly_w >= y_w) && (ly_w < y_w + CW'(SPR_H));
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ly_d     = ly_q;
        row_d    = row_q;
        act_d    = act_q;
        rom_addr = '0;

        case (state_q)
            IDLE: begin
                if (line_start) begin
                    ly_d    = line_y;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (scan_hit) begin
                    rom_addr = AW'(ly_q - spr_y_arr[idx_q]);
                end
                row_d[idx_q] = scan_hit ? rom_data : '0;
                act_d[idx_q] = scan_hit;

                // A fresh line_start wins over finishing the current walk
                if (line_start) begin
                    ly_d  = line_y;
                    idx_d = '0;
                end else if (idx_q == IW'(NSPR - 1)) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        paint_d    = |hit;
        paint_id_d = 3'd0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (hit[i]) begin
                paint_id_d = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ly_q       <= '0;
            act_q      <= '0;
            paint_q    <= 1'b0;
            paint_id_q <= 3'd0;
            for (int i = 0; i < NSPR; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ly_q       <= ly_d;
            act_q      <= act_d;
            paint_q    <= paint_d;
            paint_id_q <= paint_id_d;
            for (int i = 0; i < NSPR; i++) begin
                row_q[i] <= row_d[i];
            end
        end
    end

    assign paint    = paint_q;
    assign paint_id = paint_id_q;
    assign busy     = (state_q == SCAN);

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: one task per scenario, ROM modelled inline.
module tb_sprite_line_scheduler;

    localparam int NSPR  = 4;
    localparam int SPR_W = 40;
    localparam int SPR_H = 24;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                line_start = 1'b0;
    logic [10:0]         line_y = '0;
    logic [10:0]         pix_x = '0;
    logic                video_on = 1'b0;
    logic [NSPR-1:0]     spr_en = '0;
    logic [NSPR*11-1:0]  spr_x;
    logic [NSPR*11-1:0]  spr_y;
    logic [AW-1:0]       rom_addr;
    logic [SPR_W-1:0]    rom_data;
    logic                paint;
    logic [2:0]          paint_id;
    logic                busy;

    logic [10:0]         sx [NSPR];
    logic [10:0]         sy [NSPR];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NSPR; i++) begin
            spr_x[i*11 +: 11] = sx[i];
            spr_y[i*11 +: 11] = sy[i];
        end
    end

    // Sprite ROM: row 10 has only the two edge pixels lit, every other row is solid
    always_comb begin
        rom_data = (rom_addr == 5'd10) ? 40'h80_0000_0001 : {SPR_W{1'b1}};
    end

    sprite_line_scheduler #(
        .NSPR  (NSPR),
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .line_y     (line_y),
        .pix_x      (pix_x),
        .video_on   (video_on),
        .spr_en     (spr_en),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .paint      (paint),
        .paint_id   (paint_id),
        .busy       (busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic scan_line(input logic [10:0] y, output logic [AW-1:0] a0, output int nb);
        line_y     = y;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        a0 = rom_addr;
        nb = 0;
        while (busy && nb < 16) begin
            nb++;
            tick();
        end
        $display("scan line_y=%0d first_rom_addr=%0d busy_cycles=%0d", y, a0, nb);
    endtask

    task automatic pix(input logic [10:0] x, output logic p, output logic [2:0] id);
        pix_x    = x;
        video_on = 1'b1;
        tick();
        p  = paint;
        id = paint_id;
        $display("pixel x=%0d paint=%0d paint_id=%0d", x, p, id);
    endtask

    task automatic count_paint(input int lo, input int hi, output int n);
        logic       p;
        logic [2:0] id;
        n = 0;
        for (int x = lo; x <= hi; x++) begin
            pix(11'(x), p, id);
            if (p) n++;
        end
    endtask

    task automatic test_reset();
        int n;
        for (int i = 0; i < NSPR; i++) begin
            sx[i] = 11'd100;
            sy[i] = 11'd50;
        end
        spr_en = '1;
        rst_n  = 1'b0;
        video_on = 1'b1;
        pix_x  = 11'd100;
        repeat (3) tick();
        checks++;
        if (paint !== 1'b0) begin errors++; $display("FAIL reset_paint got=%0d want=0", paint); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0d want=0", busy); end
        checks++;
        if (rom_addr !== 5'd0) begin errors++; $display("FAIL reset_rom_addr got=%0d want=0", rom_addr); end
        checks++;
        if (paint_id !== 3'd0) begin errors++; $display("FAIL reset_paint_id got=%0d want=0", paint_id); end
        rst_n = 1'b1;
        tick();
        count_paint(95, 145, n);
        checks++;
        if (n != 0) begin errors++; $display("FAIL reset_rows_clear painted=%0d want=0", n); end
        spr_en = '0;
    endtask

    task automatic test_basic_row();
        logic [AW-1:0] a0;
        int            nb, n;
        logic          p;
        logic [2:0]    id;
        sx[0] = 11'd100; sy[0] = 11'd50;
        spr_en = 4'b0001;
        scan_line(11'd60, a0, nb);
        checks++;
        if (a0 !== 5'd10) begin errors++; $display("FAIL basic_rom_addr got=%0d want=10", a0); end
        checks++;
        if (nb != NSPR) begin errors++; $display("FAIL basic_busy_len got=%0d want=%0d", nb, NSPR); end
        pix(11'd100, p, id);
        checks++;
        if (p !== 1'b1 || id !== 3'd0) begin errors++; $display("FAIL basic_left_edge got=%0d/%0d want=1/0", p, id); end
        count_paint(101, 138, n);
        checks++;
        if (n != 0) begin errors++; $display("FAIL basic_interior painted=%0d want=0", n); end
        pix(11'd139, p, id);
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL basic_right_edge got=%0d want=1", p); end
        pix(11'd140, p, id);
        checks++;
        if (p !== 1'b0) begin errors++; $display("FAIL basic_past_right got=%0d want=0", p); end
        pix(11'd99, p, id);
        checks++;
        if (p !== 1'b0) begin errors++; $display("FAIL basic_before_left got=%0d want=0", p); end
        pix_x = 11'd100;
        video_on = 1'b0;
        tick();
        checks++;
        if (paint !== 1'b0) begin errors++; $display("FAIL basic_video_off got=%0d want=0", paint); end
    endtask

    task automatic test_vertical_bounds();
        logic [AW-1:0] a0;
        int            nb, n;
        logic          p;
        logic [2:0]    id;
        scan_line(11'd49, a0, nb);
        count_paint(95, 145, n);
        checks++;
        if (n != 0) begin errors++; $display("FAIL vbound_above painted=%0d want=0", n); end
        scan_line(11'd73, a0, nb);
        checks++;
        if (a0 !== 5'd23) begin errors++; $display("FAIL vbound_last_addr got=%0d want=23", a0); end
        pix(11'd120, p, id);
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL vbound_last_row got=%0d want=1", p); end
        scan_line(11'd74, a0, nb);
        checks++;
        if (a0 !== 5'd0) begin errors++; $display("FAIL vbound_below_addr got=%0d want=0", a0); end
        count_paint(95, 145, n);
        checks++;
        if (n != 0) begin errors++; $display("FAIL vbound_below painted=%0d want=0", n); end
    endtask

    task automatic test_overlap();
        logic [AW-1:0] a0;
        int            nb, bad;
        logic          p;
        logic [2:0]    id;
        sx[1] = 11'd200; sy[1] = 11'd100;
        sx[2] = 11'd200; sy[2] = 11'd100;
        spr_en = 4'b0110;
        scan_line(11'd100, a0, nb);
        bad = 0;
        for (int x = 200; x <= 239; x++) begin
            pix(11'(x), p, id);
            if (p !== 1'b1 || id !== 3'd1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL overlap_id1 wrong_pixels=%0d want=0", bad); end
        pix(11'd240, p, id);
        checks++;
        if (p !== 1'b0 || id !== 3'd0) begin errors++; $display("FAIL overlap_past got=%0d/%0d want=0/0", p, id); end
        spr_en = 4'b0100;
        scan_line(11'd100, a0, nb);
        pix(11'd220, p, id);
        checks++;
        if (p !== 1'b1 || id !== 3'd2) begin errors++; $display("FAIL overlap_id2 got=%0d/%0d want=1/2", p, id); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a0;
        int            nb;
        logic          p;
        logic [2:0]    id;
        sx[3] = 11'd2030; sy[3] = 11'd2040;
        spr_en = 4'b1000;
        scan_line(11'd5, a0, nb);
        checks++;
        if (a0 !== 5'd0) begin errors++; $display("FAIL wrap_y_addr got=%0d want=0", a0); end
        pix(11'd3, p, id);
        checks++;
        if (p !== 1'b0) begin errors++; $display("FAIL wrap_x_paint got=%0d want=0", p); end
        scan_line(11'd2045, a0, nb);
        pix(11'd2030, p, id);
        checks++;
        if (p !== 1'b1 || id !== 3'd3) begin errors++; $display("FAIL wrap_in_range got=%0d/%0d want=1/3", p, id); end
        pix(11'd3, p, id);
        checks++;
        if (p !== 1'b0) begin errors++; $display("FAIL wrap_x_loaded got=%0d want=0", p); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a0;
        int            nb;
        logic          p;
        logic [2:0]    id;
        sx[0] = 11'd100; sy[0] = 11'd50;
        sx[1] = 11'd300; sy[1] = 11'd80;
        spr_en = 4'b0011;
        scan_line(11'd85, a0, nb);
        pix(11'd300, p, id);
        checks++;
        if (p !== 1'b1 || id !== 3'd1) begin errors++; $display("FAIL restart_preload got=%0d/%0d want=1/1", p, id); end
        line_y = 11'd85; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        line_y = 11'd60; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        a0 = rom_addr;
        nb = 0;
        while (busy && nb < 16) begin
            nb++;
            tick();
        end
        $display("restart line_y=60 first_rom_addr=%0d busy_cycles=%0d", a0, nb);
        checks++;
        if (a0 !== 5'd10) begin errors++; $display("FAIL restart_addr got=%0d want=10", a0); end
        checks++;
        if (nb != NSPR) begin errors++; $display("FAIL restart_busy_len got=%0d want=%0d", nb, NSPR); end
        pix(11'd100, p, id);
        checks++;
        if (p !== 1'b1 || id !== 3'd0) begin errors++; $display("FAIL restart_new_row got=%0d/%0d want=1/0", p, id); end
        pix(11'd300, p, id);
        checks++;
        if (p !== 1'b0) begin errors++; $display("FAIL restart_old_row got=%0d want=0", p); end
        line_y = 11'd60; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        $display("reset mid-scan busy=%0d rom_addr=%0d", busy, rom_addr);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midscan_reset_busy got=%0d want=0", busy); end
        pix(11'd100, p, id);
        checks++;
        if (p !== 1'b0) begin errors++; $display("FAIL midscan_reset_row0 got=%0d want=0", p); end
        pix(11'd139, p, id);
        checks++;
        if (p !== 1'b0) begin errors++; $display("FAIL midscan_reset_row0_right got=%0d want=0", p); end
    endtask

    initial begin
        for (int i = 0; i < NSPR; i++) begin
            sx[i] = '0;
            sy[i] = '0;
        end
        test_reset();
        test_basic_row();
        test_vertical_bounds();
        test_overlap();
        test_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

Shares one combinational 40x24 sprite-image ROM among `NSPR` on-screen sprites of the VGA game. During horizontal blanking it walks the sprite list and fetches each visible sprite's row for the upcoming scanline into a per-sprite row register. During active video it produces a registered `paint`/`paint_id` pair for the pixel pipeline. It replaces one ROM instance per sprite with one ROM plus this scheduler, and sits between the VGA timing generator and the colour mux.

## Interface
Parameters:
- `NSPR`, default 4: number of sprites, 1..8.
- `SPR_W`, default 40: sprite width in pixels, equal to the ROM word width.
- `SPR_H`, default 24: sprite height in rows.
- `AW`, default 5: ROM address width, with `2**AW >= SPR_H`.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: synchronous, active-low reset.
- `line_start` in 1: one-cycle pulse at the start of horizontal blanking.
- `line_y` in 11: scanline to be displayed next. Sampled on `line_start`.
- `pix_x` in 11: current pixel column.
- `video_on` in 1: active-video flag.
- `spr_en` in `NSPR`: per-sprite enable. Sampled during SCAN.
- `spr_x` in `NSPR*11`: sprite left edge, packed, sprite i at `[11i+10:11i]`.
- `spr_y` in `NSPR*11`: sprite top edge, packed like `spr_x`.
- `rom_addr` out `AW`: ROM row address.
- `rom_data` in `SPR_W`: ROM row, combinational from `rom_addr`. Bit `SPR_W-1` is the leftmost pixel.
- `paint` out 1: registered; some sprite covers the pixel.
- `paint_id` out 3: registered; lowest-index sprite covering the pixel.
- `busy` out 1: high while in SCAN.

## Operation
State machine states are IDLE and SCAN.

- **IDLE:**
  - `rom_addr = 0`.
  - On `line_start`: latch `line_y` into `ly`, set sprite counter `idx = 0`, go to SCAN.
- **SCAN** (one sprite per cycle):
  - Sprite `idx` is a hit when all of the following hold:
    - `spr_en[idx]`
    - `ly >= spr_y[idx]`
    - `ly < spr_y[idx] + SPR_H`
  - Compare in 12 bits so `spr_y + SPR_H` cannot wrap.
  - On a hit: drive `rom_addr = ly - spr_y[idx]`, truncated to `AW`. On the clock edge, load `row[idx] <= rom_data` and `act[idx] <= 1`.
  - On a miss: drive `rom_addr = 0`, load `row[idx] <= 0` and `act[idx] <= 0`.
  - `idx == NSPR-1` → return to IDLE. Otherwise `idx` increments.
- **`line_start` during SCAN:** relatch `line_y`, restart at `idx = 0`. Rows already loaded are overwritten as the new scan reaches them.
- **Pixel stage** (combinational hit, registered output). For each sprite i:
  - `hit_i = act[i] & video_on & pix_x >= spr_x[i] & pix_x < spr_x[i] + SPR_W & row[i][SPR_W-1-(pix_x-spr_x[i])]`.
  - Compare in 12 bits.
  - `paint <= |hit`.
  - `paint_id <=` index of the lowest set `hit_i`, or 0 when no hit.
- Position inputs may change at any time. The row fetched uses the `spr_y` present in that sprite's SCAN cycle.
- **Edge cases:**
  - Sprites overlapping: lowest index wins `paint_id`.
  - `NSPR` below 8: unused `paint_id` codes never occur.

## Timing
- **Reset values:**
  - `rom_addr = 0`, `paint = 0`, `paint_id = 0`, `busy = 0`.
  - All `row = 0`, all `act = 0`.
  - State IDLE.
  - Reset asserted mid-SCAN aborts the scan and clears all rows.
- **Scan length:**
  - SCAN lasts exactly `NSPR` cycles after the `line_start` edge.
  - `busy` is high on those `NSPR` cycles.
  - The blanking interval must be at least `NSPR+1` cycles. This is guaranteed by 640x480 timing.
- **Row latency:** the row for sprite i is usable from cycle `line_start + i + 2`.
- **Pixel latency:** `paint`/`paint_id` lag `pix_x` by one cycle. The timing generator delays RGB accordingly.
- **ROM:** `rom_addr` is combinational from state/`idx`/`spr_y`/`ly`. No registered-ROM support is required.

## Structure
- **Package `sprite_pkg`:**
  - Constants `SPR_W`, `SPR_H`, `COORD_W = 11`.
  - `typedef enum logic {IDLE, SCAN} sched_state_t`.
  - `typedef logic [COORD_W-1:0] coord_t`.
- **Sub-module `sprite_pixel_hit`** (one per sprite, combinational):
  - Inputs: row, act, `spr_x`, `pix_x`, `video_on`.
  - Output: `hit_i`.
- **Top-level:** FSM, row registers, priority encoder, output registers.

## Test plan
1. Reset with `NSPR = 4`: hold `rst_n = 0` for 3 cycles → `paint = 0`, `busy = 0`, `rom_addr = 0`; after release all rows are 0.
2. Sprite 0 at (100, 50), ROM row 10 = `0x80_0000_0001`. Send `line_start` with `line_y = 60`:
   - `rom_addr = 10` on the first SCAN cycle.
   - Then `pix_x = 100` → `paint = 1` next cycle.
   - `pix_x = 101..138` → `paint = 0`.
   - `pix_x = 139` → `paint = 1`.
3. Vertical boundaries:
   - `line_y = 49` → no paint anywhere.
   - `line_y = 73` → `rom_addr = 23`.
   - `line_y = 74` → no paint.
4. Overlap: sprites 1 and 2 both at (200, 100), full rows, `line_y = 100` → `paint_id = 1` for `pix_x` 200..239.
5. Wrap: sprite 3 at `spr_y = 2040`, `line_y = 5` → no hit (12-bit compare). `spr_x = 2030`, `pix_x = 3` → no paint.
6. `line_start` reasserted on the second SCAN cycle with a new `line_y` → scan restarts, `busy` stays high for 4 more cycles, rows reflect the new line. Reset asserted mid-SCAN → all rows cleared.
